// File: rtl/spi_peripheral_cfg.sv
// Configurable SPI target: word width, CPOL/CPHA, bit order, valid/ready TX load
// and RX paths with overrun and frame-abort pulses. Everything runs in clk.
module spi_peripheral_cfg #(
    parameter int          DATA_W      = 8,
    parameter int          CPOL        = 0,
    parameter int          CPHA        = 0,
    parameter int          MSB_FIRST   = 1,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] TX_DEFAULT  = 32'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCLK,
    input  logic              COPI,
    input  logic              CS,
    output logic              CIPO,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              overrun,
    output logic              frame_abort,
    output logic              busy
);

    localparam logic                IDLE_LVL = (CPOL != 0);
    localparam bit                  PHA1     = (CPHA != 0);
    localparam bit                  MSB      = (MSB_FIRST != 0);
    localparam int                  CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0]   TX_DEF   = TX_DEFAULT[DATA_W-1:0];

    typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, cs_sync;
    logic                   sclk_s, copi_s, cs_s, sclk_d;
    logic                   lead_q, trail_q;
    logic                   sample_edge, shift_edge;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      tx_shreg, rx_shreg, rx_next, tx_word;
    logic                   cipo_q;
    logic                   load_tx, word_done, abort;

    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return MSB ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return MSB ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign copi_s = copi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    // Edge pulses are registered so the whole pin-to-rx_valid path is SYNC_STAGES+2.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
            copi_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= IDLE_LVL;
            lead_q    <= 1'b0;
            trail_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge
            // value, which is what turns this chain into a real synchroniser.
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            sclk_d    <= sclk_s;
            lead_q    <= (sclk_s != IDLE_LVL) && (sclk_d == IDLE_LVL);
            trail_q   <= (sclk_s == IDLE_LVL) && (sclk_d != IDLE_LVL);
        end
    end

    assign sample_edge = PHA1 ? trail_q : lead_q;
    assign shift_edge  = PHA1 ? lead_q : trail_q;

    assign rx_next  = MSB ? {rx_shreg[DATA_W-2:0], copi_s} : {copi_s, rx_shreg[DATA_W-1:1]};
    assign tx_word  = tx_valid ? tx_data : TX_DEF;
    assign tx_ready = load_tx && tx_valid && rst;
    assign busy     = ~cs_s;
    assign CIPO     = cipo_q;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_next = state;
        load_tx    = 1'b0;
        word_done  = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_s) begin
                    load_tx    = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: state_next = cs_s ? IDLE : XFER;
            XFER: begin
                if (cs_s) begin
                    state_next = IDLE;
                    abort      = (bit_cnt != '0);
                end else if (sample_edge && bit_cnt == LAST_BIT) begin
                    word_done = 1'b1;
                    load_tx   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the shift registers are reset along with the control state;
            // they are only a few flops and this keeps post-reset waveforms free of X.
            bit_cnt     <= '0;
            tx_shreg    <= '0;
            rx_shreg    <= '0;
            cipo_q      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            overrun     <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            overrun     <= 1'b0;
            frame_abort <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cipo_q  <= 1'b0;
                    bit_cnt <= '0;
                    if (load_tx) tx_shreg <= tx_word;
                end
                LOAD: begin
                    if (cs_s) begin
                        cipo_q <= 1'b0;
                    end else if (!PHA1) begin
                        cipo_q   <= head_bit(tx_shreg);
                        tx_shreg <= advance(tx_shreg);
                    end
                end
                XFER: begin
                    if (cs_s) begin
                        cipo_q      <= 1'b0;
                        bit_cnt     <= '0;
                        frame_abort <= abort;
                    end else if (sample_edge) begin
                        rx_shreg <= rx_next;
                        if (word_done) begin
                            bit_cnt <= '0;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            // Mode with CPHA=0 needs the new first bit on the line
                            // before the next leading edge.
                            if (!PHA1) begin
                                cipo_q   <= head_bit(tx_word);
                                tx_shreg <= advance(tx_word);
                            end else begin
                                tx_shreg <= tx_word;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (shift_edge && (PHA1 || bit_cnt != '0)) begin
                        cipo_q   <= head_bit(tx_shreg);
                        tx_shreg <= advance(tx_shreg);
                    end
                end
                default: begin
                    cipo_q  <= 1'b0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral_cfg.sv
// Bench for spi_peripheral_cfg: three instances (mode 0 / 8-bit, mode 3 / 16-bit,
// mode 0 / LSB-first) share one SPI driver; received words go through a scoreboard queue.
module tb_spi_peripheral_cfg;

    localparam int HALF = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, drv_sclk, drv_cs, drv_copi, rx_ready, tx_valid;
    logic [31:0] tx_data;
    int          sel;

    logic        cur_cpol, cur_cpha, cur_msb;
    int          cur_w;

    logic        sclk0, sclk1, sclk2, cs0, cs1, cs2;
    logic        cipo0, cipo1, cipo2, rxv0, rxv1, rxv2, txr0, txr1, txr2;
    logic        ovr0, ovr1, ovr2, fab0, fab1, fab2, busy0, busy1, busy2;
    logic [7:0]  rxd0, rxd2;
    logic [15:0] rxd1;

    assign sclk0 = (sel == 0) ? drv_sclk : 1'b0;
    assign sclk1 = (sel == 1) ? drv_sclk : 1'b1;
    assign sclk2 = (sel == 2) ? drv_sclk : 1'b0;
    assign cs0   = (sel == 0) ? drv_cs : 1'b1;
    assign cs1   = (sel == 1) ? drv_cs : 1'b1;
    assign cs2   = (sel == 2) ? drv_cs : 1'b1;

    spi_peripheral_cfg u_m0 (
        .clk(clk), .rst(rst), .SCLK(sclk0), .COPI(drv_copi), .CS(cs0), .CIPO(cipo0),
        .rx_data(rxd0), .rx_valid(rxv0), .rx_ready(rx_ready), .tx_data(tx_data[7:0]),
        .tx_valid(tx_valid), .tx_ready(txr0), .overrun(ovr0), .frame_abort(fab0), .busy(busy0)
    );

    spi_peripheral_cfg #(.DATA_W(16), .CPOL(1), .CPHA(1)) u_m3 (
        .clk(clk), .rst(rst), .SCLK(sclk1), .COPI(drv_copi), .CS(cs1), .CIPO(cipo1),
        .rx_data(rxd1), .rx_valid(rxv1), .rx_ready(rx_ready), .tx_data(tx_data[15:0]),
        .tx_valid(tx_valid), .tx_ready(txr1), .overrun(ovr1), .frame_abort(fab1), .busy(busy1)
    );

    spi_peripheral_cfg #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .SCLK(sclk2), .COPI(drv_copi), .CS(cs2), .CIPO(cipo2),
        .rx_data(rxd2), .rx_valid(rxv2), .rx_ready(rx_ready), .tx_data(tx_data[7:0]),
        .tx_valid(tx_valid), .tx_ready(txr2), .overrun(ovr2), .frame_abort(fab2), .busy(busy2)
    );

    logic        cur_cipo, cur_rx_valid, cur_tx_ready, cur_overrun, cur_frame_abort, cur_busy;
    logic [31:0] cur_rx_data;

    always_comb begin
        case (sel)
            1: begin
                cur_cipo = cipo1; cur_rx_valid = rxv1; cur_tx_ready = txr1; cur_overrun = ovr1;
                cur_frame_abort = fab1; cur_busy = busy1; cur_rx_data = {16'h0, rxd1};
            end
            2: begin
                cur_cipo = cipo2; cur_rx_valid = rxv2; cur_tx_ready = txr2; cur_overrun = ovr2;
                cur_frame_abort = fab2; cur_busy = busy2; cur_rx_data = {24'h0, rxd2};
            end
            default: begin
                cur_cipo = cipo0; cur_rx_valid = rxv0; cur_tx_ready = txr0; cur_overrun = ovr0;
                cur_frame_abort = fab0; cur_busy = busy0; cur_rx_data = {24'h0, rxd0};
            end
        endcase
    end

    int          total = 0;
    int          bad = 0;
    int          n_txr, n_ovr, n_fab, n_hs;
    int          lat;
    logic [31:0] rx_exp[$];
    logic [31:0] exp_w;

    // Scoreboard monitor: counts pulses and checks every rx handshake against the queue.
    always begin
        @(negedge clk);
        #1;
        if (rst === 1'b1) begin
            if (cur_tx_ready === 1'b1)    n_txr++;
            if (cur_overrun === 1'b1)     n_ovr++;
            if (cur_frame_abort === 1'b1) n_fab++;
            if (cur_rx_valid === 1'b1 && rx_ready === 1'b1) begin
                n_hs++;
                total++;
                if (rx_exp.size() == 0) begin
                    bad++;
                    $display("FAIL rx_unexpected: got word %h, no word was expected", cur_rx_data);
                end else begin
                    exp_w = rx_exp.pop_front();
                    if (cur_rx_data !== exp_w) begin
                        bad++;
                        $display("FAIL rx_word: got %h, expected %h", cur_rx_data, exp_w);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic half_watch();
        for (int k = 1; k <= HALF; k++) begin
            @(negedge clk);
            if (lat == 0 && cur_rx_valid === 1'b1) lat = k;
        end
    endtask

    task automatic clear_counts();
        n_txr = 0; n_ovr = 0; n_fab = 0; n_hs = 0;
    endtask

    task automatic select_dut(input int s);
        drv_cs   = 1'b1;
        cur_cpol = (s == 1);
        cur_cpha = (s == 1);
        cur_w    = (s == 1) ? 16 : 8;
        cur_msb  = (s != 2);
        drv_sclk = cur_cpol;
        drv_copi = 1'b0;
        sel      = s;
        wait_clk(4);
    endtask

    task automatic cs_low(input bit drop_on_ready);
        bit seen;
        seen   = 1'b0;
        drv_cs = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            @(negedge clk);
            if (seen && drop_on_ready) tx_valid = 1'b0;
            if (cur_tx_ready === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        drv_cs = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic send_word(input logic [31:0] mosi, input int nbits, output logic [31:0] miso);
        miso = '0;
        lat  = 0;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = cur_msb ? cur_w - 1 - i : i;
            if (!cur_cpha) begin
                drv_copi = mosi[b];
                wait_clk(HALF);
                miso[b]  = cur_cipo;
                drv_sclk = ~cur_cpol;
                half_watch();
                drv_sclk = cur_cpol;
            end else begin
                drv_sclk = ~cur_cpol;
                drv_copi = mosi[b];
                wait_clk(HALF);
                miso[b]  = cur_cipo;
                drv_sclk = cur_cpol;
                half_watch();
            end
        end
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        wait_clk(3);
        obs = {cur_cipo, cur_rx_valid, cur_tx_ready, cur_overrun, cur_frame_abort, cur_busy, rxd0};
        total++;
        if (obs !== 15'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h, expected 0000", obs);
        end
        rst = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_mode0_tx_load();
        logic [31:0] miso;
        select_dut(0);
        clear_counts();
        tx_data  = 32'h5A;
        tx_valid = 1'b1;
        rx_ready = 1'b1;
        cs_low(1'b1);
        total++;
        if (cur_busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_in_frame: got %b, expected 1", cur_busy);
        end
        rx_exp.push_back(32'h3C);
        send_word(32'h3C, 8, miso);
        total++;
        if (miso !== 32'h5A) begin
            bad++;
            $display("FAIL mode0_cipo: got %h, expected 5a", miso);
        end
        expect_int("mode0_latency", lat, 4);
        cs_high();
        expect_int("mode0_tx_ready_pulses", n_txr, 1);
        expect_int("mode0_handshakes", n_hs, 1);
        expect_int("mode0_frame_abort", n_fab, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] miso;
        clear_counts();
        tx_valid = 1'b0;
        cs_low(1'b0);
        rx_exp.push_back(32'hC3);
        send_word(32'hC3, 8, miso);
        total++;
        if (miso !== 32'hA5) begin
            bad++;
            $display("FAIL b2b_cipo_first: got %h, expected a5", miso);
        end
        rx_exp.push_back(32'h7E);
        send_word(32'h7E, 8, miso);
        total++;
        if (miso !== 32'hA5) begin
            bad++;
            $display("FAIL b2b_cipo_second: got %h, expected a5", miso);
        end
        cs_high();
        expect_int("b2b_handshakes", n_hs, 2);
        expect_int("b2b_tx_ready_pulses", n_txr, 0);
        expect_int("b2b_queue_left", rx_exp.size(), 0);
    endtask

    task automatic test_mode3_wide();
        logic [31:0] miso;
        select_dut(1);
        clear_counts();
        wait_clk(8);
        expect_int("mode3_idle_valid", int'(cur_rx_valid), 0);
        tx_data  = 32'h1234;
        tx_valid = 1'b1;
        cs_low(1'b1);
        rx_exp.push_back(32'hBEEF);
        send_word(32'hBEEF, 16, miso);
        total++;
        if (miso !== 32'h1234) begin
            bad++;
            $display("FAIL mode3_cipo: got %h, expected 1234", miso);
        end
        expect_int("mode3_latency", lat, 4);
        cs_high();
        expect_int("mode3_handshakes", n_hs, 1);
        expect_int("mode3_tx_ready_pulses", n_txr, 1);
        expect_int("mode3_frame_abort", n_fab, 0);
    endtask

    task automatic test_overrun();
        logic [31:0] miso;
        select_dut(0);
        clear_counts();
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        cs_low(1'b0);
        rx_exp.push_back(32'h11);
        send_word(32'h11, 8, miso);
        send_word(32'h22, 8, miso);
        cs_high();
        total++;
        if (cur_rx_valid !== 1'b1 || cur_rx_data !== 32'h11) begin
            bad++;
            $display("FAIL overrun_hold: got valid=%b data=%h, expected valid=1 data=11",
                     cur_rx_valid, cur_rx_data);
        end
        expect_int("overrun_pulses", n_ovr, 1);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        #2;
        expect_int("overrun_valid_drop", int'(cur_rx_valid), 0);
        expect_int("overrun_handshakes", n_hs, 1);
        expect_int("overrun_queue_left", rx_exp.size(), 0);
    endtask

    task automatic test_abort_and_lsb();
        logic [31:0] miso;
        clear_counts();
        cs_low(1'b0);
        send_word(32'hFF, 5, miso);
        cs_high();
        expect_int("abort_pulses", n_fab, 1);
        expect_int("abort_no_valid", n_hs, 0);
        cs_low(1'b0);
        rx_exp.push_back(32'h81);
        send_word(32'h81, 8, miso);
        cs_high();
        expect_int("abort_next_frame", n_hs, 1);
        expect_int("abort_pulses_after", n_fab, 1);
        select_dut(2);
        cs_low(1'b0);
        rx_exp.push_back(32'h01);
        send_word(32'h01, 8, miso);
        cs_high();
        total++;
        if (miso !== 32'hA5) begin
            bad++;
            $display("FAIL lsb_cipo: got %h, expected a5", miso);
        end
        expect_int("lsb_handshakes", n_hs, 2);
        expect_int("lsb_queue_left", rx_exp.size(), 0);
    endtask

    task automatic test_reset_mid_word();
        logic [31:0] miso;
        logic [14:0] obs;
        select_dut(0);
        clear_counts();
        tx_data  = 32'hFF;
        tx_valid = 1'b1;
        cs_low(1'b1);
        send_word(32'hAA, 4, miso);
        wait_clk(2);
        expect_int("pre_reset_cipo", int'(cur_cipo), 1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        obs = {cur_cipo, cur_rx_valid, cur_tx_ready, cur_overrun, cur_frame_abort, cur_busy, rxd0};
        total++;
        if (obs !== 15'h0) begin
            bad++;
            $display("FAIL reset_mid_word: got %h, expected 0000", obs);
        end
        rst = 1'b1;
        cs_high();
        expect_int("reset_no_abort", n_fab, 0);
        expect_int("reset_no_valid", n_hs, 0);
        cs_low(1'b0);
        rx_exp.push_back(32'h55);
        send_word(32'h55, 8, miso);
        cs_high();
        expect_int("reset_next_frame", n_hs, 1);
        expect_int("reset_queue_left", rx_exp.size(), 0);
    endtask

    initial begin
        rst      = 1'b0;
        sel      = 0;
        drv_sclk = 1'b0;
        drv_cs   = 1'b1;
        drv_copi = 1'b0;
        rx_ready = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        cur_cpol = 1'b0;
        cur_cpha = 1'b0;
        cur_msb  = 1'b1;
        cur_w    = 8;
        clear_counts();
        lat = 0;

        test_reset();
        test_mode0_tx_load();
        test_back_to_back();
        test_mode3_wide();
        test_overrun();
        test_abort_and_lsb();
        test_reset_mid_word();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
